gyrator_array_dsp: RTL and testbench

//  Multi-channel, fixed-point discrete-time gyrator engine for mixed-signal co-simulation benches.
//  Per channel it computes port currents from sampled port voltages through a programmable

---
 rtl/gyrator_array_dsp.sv | 163 ++++++++++++++++
 tb/tb_gyrator_array_dsp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gyrator_array_dsp.sv
// Multi-channel fixed-point gyrator / dual-conductance engine with one shared multiplier.
// Optional saturation statistics counter enabled by defining GYR_STATS_EN.
module gyrator_array_dsp #(
    parameter int            NCH      = 4,
    parameter int            DW       = 16,
    parameter int            GW       = 16,
    parameter int            FRAC     = 12,
    parameter logic [GW-1:0] GAIN_RST = 'h1000,
    parameter int            CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [GW-1:0]        cfg_gain,
    input  logic                 cfg_mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [CW-1:0]        s_ch,
    input  logic signed [DW-1:0] s_v1,
    input  logic signed [DW-1:0] s_v2,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CW-1:0]        m_ch,
    output logic signed [DW-1:0] m_i1,
    output logic signed [DW-1:0] m_i2,
    output logic                 m_sat,
    output logic                 m_err,
    output logic [15:0]          stat_sat_cnt
);

    localparam int PW = DW + GW;
    localparam int XW = PW + 1;

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

    state_t state, state_nx;

    logic [GW-1:0]        gain_q [NCH];
    logic [NCH-1:0]       mode_q;
    logic [CW-1:0]        ch_q;
    logic signed [DW-1:0] v1_q, v2_q;
    logic signed [GW-1:0] g_q;
    logic                 md_q, err_q;
    logic signed [DW-1:0] i1_q, i2_q;
    logic                 sat1_q, sat2_q;

    logic [31:0] s_ch_w, cfg_ch_w;
    logic        s_ok, cfg_ok;

    assign s_ch_w   = 32'(s_ch);
    assign cfg_ch_w = 32'(cfg_ch);
    assign s_ok     = s_ch_w < 32'(NCH);
    assign cfg_ok   = cfg_ch_w < 32'(NCH);

    assign s_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (s_valid) state_nx = MUL1;
            MUL1: state_nx = MUL2;
            MUL2: state_nx = OUT;
            OUT:  if (m_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // MUL1 produces i1, MUL2 produces i2; gyrator mode swaps operands and negates i2
    logic signed [DW-1:0] opnd;
    logic signed [PW-1:0] prod;
    logic signed [XW-1:0] prod_x, rnd, shr;
    logic                 neg, sat;
    logic signed [DW-1:0] res;

    always_comb begin
        if (state == MUL1) opnd = md_q ? v1_q : v2_q;
        else               opnd = md_q ? v2_q : v1_q;
        neg    = (state == MUL2) && !md_q;
        prod   = g_q * opnd;
        prod_x = neg ? -{prod[PW-1], prod} : {prod[PW-1], prod};
        rnd    = prod_x + (XW'(1) << (FRAC - 1));
        shr    = rnd >>> FRAC;
        sat    = !((&shr[XW-1:DW-1]) || !(|shr[XW-1:DW-1]));
        if (!sat)            res = shr[DW-1:0];
        else if (shr[XW-1])  res = {1'b1, {(DW-1){1'b0}}};
        else                 res = {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) gain_q[k] <= GAIN_RST;
            mode_q <= '0;
        end else if (cfg_we && cfg_ok) begin
            gain_q[cfg_ch] <= cfg_gain;
            mode_q[cfg_ch] <= cfg_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            v1_q   <= '0;
            v2_q   <= '0;
            g_q    <= '0;
            md_q   <= 1'b0;
            err_q  <= 1'b0;
            i1_q   <= '0;
            i2_q   <= '0;
            sat1_q <= 1'b0;
            sat2_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (s_valid) begin
                    ch_q  <= s_ch;
                    v1_q  <= s_v1;
                    v2_q  <= s_v2;
                    err_q <= !s_ok;
                    // zero gain on a bad channel forces zero, unsaturated currents
                    g_q   <= s_ok ? gain_q[s_ch] : '0;
                    md_q  <= s_ok ? mode_q[s_ch] : 1'b0;
                end
                MUL1: begin
                    i1_q   <= res;
                    sat1_q <= sat;
                end
                MUL2: begin
                    i2_q   <= res;
                    sat2_q <= sat;
                end
                default: ;
            endcase
        end
    end

    assign m_valid = (state == OUT);
    assign m_ch    = ch_q;
    assign m_i1    = i1_q;
    assign m_i2    = i2_q;
    assign m_sat   = sat1_q | sat2_q;
    assign m_err   = err_q;

`ifdef GYR_STATS_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt_q <= '0;
        else if (m_valid && m_ready && m_sat && sat_cnt_q != 16'hFFFF)
            sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign stat_sat_cnt = sat_cnt_q;
`else
    assign stat_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_gyrator_array_dsp.sv
// Directed vector bench for gyrator_array_dsp (default instance plus an NCH=3 instance).
module tb_gyrator_array_dsp;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_ch = '0;
    logic [15:0]        cfg_gain = '0;
    logic               cfg_mode = 1'b0;
    logic               s_valid = 1'b0;
    logic [1:0]         s_ch = '0;
    logic signed [15:0] s_v1 = '0;
    logic signed [15:0] s_v2 = '0;
    logic               m_ready = 1'b1;

    logic               a_s_ready, a_m_valid, a_m_sat, a_m_err;
    logic [1:0]         a_m_ch;
    logic signed [15:0] a_m_i1, a_m_i2;
    logic [15:0]        a_stat;

    logic               b_s_ready, b_m_valid, b_m_sat, b_m_err;
    logic [1:0]         b_m_ch;
    logic signed [15:0] b_m_i1, b_m_i2;
    logic [15:0]        b_stat;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gyrator_array_dsp u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain), .cfg_mode(cfg_mode),
        .s_valid(s_valid), .s_ready(a_s_ready), .s_ch(s_ch), .s_v1(s_v1), .s_v2(s_v2),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_ch(a_m_ch),
        .m_i1(a_m_i1), .m_i2(a_m_i2), .m_sat(a_m_sat), .m_err(a_m_err),
        .stat_sat_cnt(a_stat)
    );

    gyrator_array_dsp #(.NCH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain), .cfg_mode(cfg_mode),
        .s_valid(s_valid), .s_ready(b_s_ready), .s_ch(s_ch), .s_v1(s_v1), .s_v2(s_v2),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_ch(b_m_ch),
        .m_i1(b_m_i1), .m_i2(b_m_i2), .m_sat(b_m_sat), .m_err(b_m_err),
        .stat_sat_cnt(b_stat)
    );

    typedef struct {
        string              name;
        logic               we;
        logic [1:0]         ch;
        logic [15:0]        g;
        logic               md;
        logic signed [15:0] v1;
        logic signed [15:0] v2;
        logic signed [15:0] e1;
        logic signed [15:0] e2;
        logic               es;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] g, input logic md);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_gain = g; cfg_mode = md;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // returns at the negedge where m_valid is first seen; lat counts cycles after accept
    task automatic send(input logic [1:0] ch, input logic signed [15:0] v1,
                        input logic signed [15:0] v2, input logic wr,
                        input logic [15:0] g, input logic md, output int lat);
        int n;
        @(negedge clk);
        s_valid = 1'b1; s_ch = ch; s_v1 = v1; s_v2 = v2;
        if (wr) begin
            cfg_we = 1'b1; cfg_ch = ch; cfg_gain = g; cfg_mode = md;
        end
        n = 0;
        while (!a_s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", a_s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0; cfg_we = 1'b0;
        lat = 1;
        while (!a_m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("m_valid_wait", a_m_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad;
        logic signed [15:0] h1, h2;
        int exp_stat;

        vt[0] = '{"t1_ch0_unity",  1'b0, 2'd0, 16'h1000, 1'b0,  100,    200,    200,   -100,   1'b0};
        vt[1] = '{"t2_half_gyr",   1'b1, 2'd1, 16'h0800, 1'b0,   -3,      3,      2,      2,   1'b0};
        vt[2] = '{"t2_half_dual",  1'b1, 2'd1, 16'h0800, 1'b1,   -3,      3,     -1,      2,   1'b0};
        vt[3] = '{"t3_dual_sat",   1'b1, 2'd2, 16'h7FFF, 1'b1, 20000, -20000,  32767, -32768,  1'b1};
        vt[4] = '{"t3_neg_min",    1'b0, 2'd0, 16'h1000, 1'b0, -32768,    0,      0,  32767,  1'b1};
        vt[5] = '{"neg_gain_gyr",  1'b1, 2'd2, 16'hF000, 1'b0,    7,     -9,      9,      7,   1'b0};
        vt[6] = '{"round_half",    1'b1, 2'd1, 16'h0800, 1'b1,   -1,      1,      0,      1,   1'b0};

        repeat (3) @(negedge clk);
        chk("rst_s_ready", a_s_ready, 0);
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_m_i1", a_m_i1, 0);
        chk("rst_m_i2", a_m_i2, 0);
        chk("rst_m_sat_err_ch", {a_m_sat, a_m_err, a_m_ch}, 0);
        chk("rst_stat", a_stat, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_s_ready", a_s_ready, 1);

        for (int k = 0; k < 7; k++) begin
            if (vt[k].we) cfg_write(vt[k].ch, vt[k].g, vt[k].md);
            send(vt[k].ch, vt[k].v1, vt[k].v2, 1'b0, 16'h0, 1'b0, lat);
            if (k == 0) chk("latency", lat, 3);
            chk($sformatf("%s.i1", vt[k].name), a_m_i1, vt[k].e1);
            chk($sformatf("%s.i2", vt[k].name), a_m_i2, vt[k].e2);
            chk($sformatf("%s.sat", vt[k].name), a_m_sat, vt[k].es);
            chk($sformatf("%s.err", vt[k].name), a_m_err, 0);
            chk($sformatf("%s.ch", vt[k].name), a_m_ch, vt[k].ch);
        end

`ifdef GYR_STATS_EN
        exp_stat = 2;
`else
        exp_stat = 0;
`endif
        @(negedge clk);
        chk("stat_sat_cnt", a_stat, exp_stat);

        m_ready = 1'b0;
        send(2'd0, 16'sd1, 16'sd2, 1'b0, 16'h0, 1'b0, lat);
        h1 = a_m_i1;
        h2 = a_m_i2;
        chk("bp_i1", a_m_i1, 2);
        chk("bp_i2", a_m_i2, -1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!a_m_valid || a_m_i1 !== h1 || a_m_i2 !== h2 || a_s_ready) bad++;
        end
        chk("bp_hold", bad, 0);
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_m_valid_drop", a_m_valid, 0);
        chk("bp_s_ready", a_s_ready, 1);

        send(2'd3, 16'sd0, 16'sd10, 1'b1, 16'h2000, 1'b0, lat);
        chk("cfg_same_edge_old_g", a_m_i1, 10);
        chk("nch3_err", b_m_err, 1);
        chk("nch3_i1", b_m_i1, 0);
        chk("nch3_i2", b_m_i2, 0);
        chk("nch3_sat", b_m_sat, 0);
        chk("nch3_ch", b_m_ch, 3);
        chk("nch4_no_err", a_m_err, 0);
        send(2'd3, 16'sd0, 16'sd10, 1'b0, 16'h0, 1'b0, lat);
        chk("cfg_new_g", a_m_i1, 20);
        chk("nch3_err_again", b_m_err, 1);

        @(negedge clk);
        s_valid = 1'b1; s_ch = 2'd3; s_v1 = 16'sd0; s_v2 = 16'sd10;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", a_s_ready, 0);
        chk("midrst_m_valid", a_m_valid, 0);
        chk("midrst_m_i1", a_m_i1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_m_valid) bad++;
        end
        chk("midrst_no_output", bad, 0);
        chk("midrst_stat", a_stat, 0);
        send(2'd3, 16'sd0, 16'sd10, 1'b0, 16'h0, 1'b0, lat);
        chk("midrst_gain_rst", a_m_i1, 10);
        send(2'd1, 16'sd5, 16'sd7, 1'b0, 16'h0, 1'b0, lat);
        chk("midrst_mode_rst_i1", a_m_i1, 7);
        chk("midrst_mode_rst_i2", a_m_i2, -5);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
